// File: rtl/basilisc_mem_responder.sv
// Memory-side endpoint of the basilisc serial bus. It deserializes requests, strobes a single-port memory and serializes read data back.
// Define BASILISC_RESP_PARITY_EN to append a parity symbol after the response data.
module basilisc_mem_responder #(
    parameter int IO_BITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IO_BITS-1:0] tx_pins,
    input  logic               tx_fetch,
    input  logic               tx_jump,
    output logic [IO_BITS-1:0] rx_pins,
    output logic [15:0]        mem_addr,
    output logic [15:0]        mem_wdata,
    output logic               mem_re,
    output logic               mem_we,
    input  logic [15:0]        mem_rdata,
    output logic               busy,
    output logic               proto_err
);
    localparam int N = 16 / IO_BITS;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_MEM_RD = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam logic [4:0] SYM_LAST  = 5'(N - 1);
    localparam logic [4:0] DATA_LAST = 5'(N);
`ifdef BASILISC_RESP_PARITY_EN
    localparam logic [4:0] RESP_LAST = 5'(N + 1);
`else
    localparam logic [4:0] RESP_LAST = 5'(N);
`endif

    logic [2:0]  r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_sh;
    logic [15:0] r_wa;
    logic [15:0] r_data;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_fptr;
    logic        r_wr;
    logic        r_fetch;
    logic        r_perr;
`ifdef BASILISC_RESP_PARITY_EN
    logic        r_par;
`endif

    logic [15:0] w_sh_next;
    logic        w_tx_act;

    // Symbols enter at the top so the first (least significant) one ends at bit 0.
    assign w_sh_next = {tx_pins, r_sh[15:IO_BITS]};
    assign w_tx_act  = |tx_pins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_wa        <= '0;
            r_data      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fptr      <= '0;
            r_wr        <= 1'b0;
            r_fetch     <= 1'b0;
`ifdef BASILISC_RESP_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_tx_act) begin
                        case (tx_pins[1:0])
                            2'd1: begin
                                r_wr    <= 1'b0;
                                r_fetch <= tx_fetch;
                                if (tx_fetch && !tx_jump) begin
                                    r_mem_addr <= r_fptr;
                                    r_state    <= S_MEM_RD;
                                end else begin
                                    r_state <= S_ADDR;
                                end
                            end
                            2'd2: begin
                                r_wr    <= 1'b1;
                                r_fetch <= 1'b0;
                                r_state <= S_ADDR;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_ADDR: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == SYM_LAST) begin
                        r_cnt <= '0;
                        if (r_wr) begin
                            r_wa    <= w_sh_next;
                            r_state <= S_WDATA;
                        end else begin
                            r_mem_addr <= w_sh_next;
                            r_state    <= S_MEM_RD;
                        end
                    end
                end
                S_WDATA: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == SYM_LAST) begin
                        r_cnt       <= '0;
                        r_mem_addr  <= r_wa;
                        r_mem_wdata <= w_sh_next;
                        r_state     <= S_MEM_WR;
                    end
                end
                S_MEM_WR: r_state <= S_IDLE;
                S_MEM_RD: begin
                    if (r_fetch) begin
                        r_fptr <= r_mem_addr + 16'd1;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_data  <= mem_rdata;
`ifdef BASILISC_RESP_PARITY_EN
                    r_par   <= ^mem_rdata;
`endif
                    r_cnt   <= '0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt != '0 && r_cnt <= DATA_LAST) begin
                        r_data <= r_data >> IO_BITS;
                    end
                    if (r_cnt == RESP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stray symbols while the bus owes or performs an access are dropped but remembered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else if (w_tx_act && (r_state == S_MEM_RD || r_state == S_WAIT ||
                                  r_state == S_RESP   || r_state == S_MEM_WR)) begin
            r_perr <= 1'b1;
        end
    end

    always_comb begin
        rx_pins = '0;
        if (r_state == S_RESP) begin
            if (r_cnt == '0) begin
                rx_pins = {{(IO_BITS-1){1'b0}}, 1'b1};
            end else if (r_cnt <= DATA_LAST) begin
                rx_pins = r_data[IO_BITS-1:0];
            end else begin
`ifdef BASILISC_RESP_PARITY_EN
                rx_pins = {{(IO_BITS-1){1'b0}}, r_par};
`else
                rx_pins = '0;
`endif
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_re    = (r_state == S_MEM_RD);
    assign mem_we    = (r_state == S_MEM_WR);
    assign busy      = (r_state != S_IDLE);
    assign proto_err = r_perr;
endmodule

// File: tb/tb_basilisc_mem_responder.sv
// Bench for basilisc_mem_responder (IO_BITS=2, parity disabled): scoreboard of expected strobes and responses.
module tb_basilisc_mem_responder;
    localparam int IO_BITS = 2;
    localparam int N = 16 / IO_BITS;
    localparam logic [1:0] K_WR = 2'd1, K_RD = 2'd2, K_RSP = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [IO_BITS-1:0] tx_pins;
    logic               tx_fetch, tx_jump;
    logic [IO_BITS-1:0] rx_pins;
    logic [15:0]        mem_addr, mem_wdata, mem_rdata;
    logic               mem_re, mem_we, busy, proto_err;

    logic [15:0] mem [0:65535];
    exp_t        sbq [$];
    int          n_vec = 0;
    int          n_bad = 0;

    basilisc_mem_responder #(.IO_BITS(IO_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .tx_pins(tx_pins), .tx_fetch(tx_fetch),
        .tx_jump(tx_jump), .rx_pins(rx_pins), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per strobe or completed response.
    logic        m_col = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_word = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_col = 1'b0;
        end else begin
            if (mem_we) begin
                if (sbq.size() == 0) chk("unexpected_we", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("we_kind", 32'(e.kind), 32'(K_WR));
                    chk("we_addr", 32'(mem_addr), 32'(e.addr));
                    chk("we_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (mem_re) begin
                if (sbq.size() == 0) chk("unexpected_re", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("re_kind", 32'(e.kind), 32'(K_RD));
                    chk("re_addr", 32'(mem_addr), 32'(e.addr));
                end
            end
            if (m_col) begin
                m_word[IO_BITS*m_idx +: IO_BITS] = rx_pins;
                m_idx++;
                if (m_idx == N) begin
                    m_col = 1'b0;
                    if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
                    else begin
                        e = sbq.pop_front();
                        chk("rsp_kind", 32'(e.kind), 32'(K_RSP));
                        chk("rsp_data", 32'(m_word), 32'(e.data));
                    end
                end
            end else if (rx_pins != '0) begin
                chk("rsp_start", 32'(rx_pins), 32'd1);
                m_col  = 1'b1;
                m_idx  = 0;
                m_word = '0;
            end
        end
    end

    task automatic send_sym(input logic [IO_BITS-1:0] s, input logic f, input logic j);
        @(negedge clk);
        tx_pins = s; tx_fetch = f; tx_jump = j;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < N; i++) send_sym(w[IO_BITS*i +: IO_BITS], 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        tx_pins = '0; tx_fetch = 1'b0; tx_jump = 1'b0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        sbq.push_back('{K_WR, a, d});
        send_sym(2'd2, 1'b1, 1'b1);
        send_word(a);
        send_word(d);
        wait_idle("write_done");
    endtask

    task automatic do_read(input logic [15:0] a, input logic f, input logic [15:0] exp_d);
        sbq.push_back('{K_RD, a, 16'h0});
        sbq.push_back('{K_RSP, 16'h0, exp_d});
        send_sym(2'd1, f, f);
        send_word(a);
        wait_idle("read_done");
    endtask

    // Sequential fetch with cycle-exact checks relative to the header cycle.
    task automatic seq_fetch(input logic [15:0] exp_a, input logic [15:0] exp_d);
        sbq.push_back('{K_RD, exp_a, 16'h0});
        sbq.push_back('{K_RSP, 16'h0, exp_d});
        send_sym(2'd1, 1'b1, 1'b0);
        @(negedge clk);
        tx_pins = '0; tx_fetch = 1'b0; tx_jump = 1'b0;
        chk("seq_re_cycle1", 32'(mem_re), 32'd1);
        chk("seq_addr", 32'(mem_addr), 32'(exp_a));
        @(negedge clk);
        chk("seq_rx_cycle2", 32'(rx_pins), 32'd0);
        @(negedge clk);
        chk("seq_start_cycle3", 32'(rx_pins), 32'd1);
        repeat (N) @(negedge clk);
        @(negedge clk);
        chk("seq_idle_busy", 32'(busy), 32'd0);
        chk("seq_idle_rx", 32'(rx_pins), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_check(input string name);
        logic bad;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rx_pins != '0 || busy || mem_re || mem_we) bad = 1'b1;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; tx_pins = '0; tx_fetch = 1'b0; tx_jump = 1'b0; mem_rdata = '0;
        mem[16'h0000] = 16'h0001;
        mem[16'h0001] = 16'h5A5A;
        mem[16'h0040] = 16'hA5C3;
        mem[16'h0041] = 16'h1E0F;
        mem[16'hFFFF] = 16'h7777;
        #2;
        chk("reset_outputs", 32'({rx_pins, mem_addr, mem_wdata, mem_re, mem_we, busy, proto_err}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle_after_reset");

        do_write(16'h1234, 16'hBEEF);
        do_read(16'h1234, 1'b0, 16'hBEEF);

        do_read(16'h0040, 1'b1, 16'hA5C3);
        seq_fetch(16'h0041, 16'h1E0F);

        do_read(16'hFFFF, 1'b1, 16'h7777);
        seq_fetch(16'h0000, 16'h0001);
        do_read(16'h0041, 1'b0, 16'h1E0F);
        seq_fetch(16'h0001, 16'h5A5A);

        chk("perr_clear", 32'(proto_err), 32'd0);
        sbq.push_back('{K_RD, 16'h0040, 16'h0});
        sbq.push_back('{K_RSP, 16'h0, 16'hA5C3});
        send_sym(2'd1, 1'b0, 1'b0);
        send_word(16'h0040);
        @(negedge clk);
        tx_pins = '0;
        k = 0;
        while (rx_pins != 2'd1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("perr_rsp_seen", 32'(rx_pins), 32'd1);
        tx_pins = 2'd3;
        @(negedge clk);
        tx_pins = '0;
        chk("perr_set", 32'(proto_err), 32'd1);
        wait_idle("perr_read_done");
        chk("perr_sticky", 32'(proto_err), 32'd1);

        send_sym(2'd3, 1'b1, 1'b1);
        @(negedge clk);
        tx_pins = '0; tx_fetch = 1'b0; tx_jump = 1'b0;
        chk("nop_busy", 32'(busy), 32'd0);
        idle_check("nop_no_strobe");
        chk("perr_still", 32'(proto_err), 32'd1);

        send_sym(2'd2, 1'b0, 1'b0);
        send_sym(2'd1, 1'b0, 1'b0);
        send_sym(2'd3, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("midtx_reset_outputs", 32'({rx_pins, mem_addr, mem_wdata, mem_re, mem_we, busy, proto_err}), 32'd0);
        tx_pins = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle_after_midtx_reset");
        chk("perr_after_reset", 32'(proto_err), 32'd0);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
